alu_rs: RTL

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs_pkg.sv | 47 ++++
 rtl/alu_rs_select.sv | 13 +
 rtl/alu_rs.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: entry layout, ALU function codes
// and the CDB wakeup helper used by both resident entries and the dispatch path.
package alu_rs_pkg;

  // Tags are stored at a fixed maximum width; the station zero-extends TAG_W tags.
  localparam int TAG_MAX = 16;

  localparam logic [3:0] FUNC_AND  = 4'b0000;
  localparam logic [3:0] FUNC_OR   = 4'b0001;
  localparam logic [3:0] FUNC_XOR  = 4'b0010;
  localparam logic [3:0] FUNC_XNOR = 4'b0011;
  localparam logic [3:0] FUNC_ADD  = 4'b0100;
  localparam logic [3:0] FUNC_SUB  = 4'b1100;
  localparam logic [3:0] FUNC_SLT  = 4'b1101;
  localparam logic [3:0] FUNC_SLTU = 4'b1110;

  typedef struct packed {
    logic               valid;
    logic [3:0]         func;
    logic               s1_rdy;
    logic [31:0]        s1_val;
    logic [TAG_MAX-1:0] s1_tag;
    logic               s2_rdy;
    logic [31:0]        s2_val;
    logic [TAG_MAX-1:0] s2_tag;
    logic [TAG_MAX-1:0] dst_tag;
  } rs_entry_t;

  // Marks any pending operand whose producer tag matches the broadcast as ready.
  function automatic rs_entry_t rs_wake(rs_entry_t e, logic cv,
                                        logic [TAG_MAX-1:0] ct, logic [31:0] cd);
    rs_entry_t r;
    r = e;
    if (e.valid && cv) begin
      if (!e.s1_rdy && e.s1_tag == ct) begin
        r.s1_rdy = 1'b1;
        r.s1_val = cd;
      end
      if (!e.s2_rdy && e.s2_tag == ct) begin
        r.s2_rdy = 1'b1;
        r.s2_val = cd;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Oldest-eligible picker: index 0 is the oldest entry, so the lowest set bit wins.
module alu_rs_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] eligible,
  output logic [N-1:0] grant,
  output logic         any
);

  assign grant = eligible & (~eligible + N'(1));
  assign any   = |eligible;

endmodule

// File: rtl/alu_rs.sv
// Age-ordered ALU reservation station with a single issue register.
// Optional ALU_RS_WAKEUP_BYPASS_EN: CDB matches count as ready for selection in the same cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [3:0]             disp_func,
  input  logic                   disp_src1_rdy,
  input  logic [31:0]            disp_src1_val,
  input  logic [TAG_W-1:0]       disp_src1_tag,
  input  logic                   disp_src2_rdy,
  input  logic [31:0]            disp_src2_val,
  input  logic [TAG_W-1:0]       disp_src2_tag,
  input  logic [TAG_W-1:0]       disp_dst_tag,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [31:0]            cdb_data,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [31:0]            iss_in1,
  output logic [31:0]            iss_in2,
  output logic [3:0]             iss_func,
  output logic [TAG_W-1:0]       iss_dst_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  rs_entry_t          q       [DEPTH];
  rs_entry_t          w       [DEPTH+1];
  rs_entry_t          sel_src [DEPTH];
  rs_entry_t          nq      [DEPTH];
  rs_entry_t          disp_raw, disp_e, pick;
  logic [DEPTH-1:0]   elig, grant;
  logic               any_elig, load_iss, iss_fire, disp_fire, past;
  logic [CW-1:0]      widx;
  logic [TAG_MAX-1:0] cdb_tag_x;
  logic               unused_pick;

  assign cdb_tag_x  = TAG_MAX'(cdb_tag);
  assign disp_ready = (count < CW'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign load_iss   = !iss_valid || iss_ready;
  assign iss_fire   = load_iss && any_elig;
  assign widx       = count - CW'(iss_fire);

  // Resident entries after this cycle's wakeup; w[DEPTH] is the empty slot shifted in on removal.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w[i] = rs_wake(q[i], cdb_valid, cdb_tag_x, cdb_data);
    w[DEPTH] = '0;
  end

`ifdef ALU_RS_WAKEUP_BYPASS_EN
  always_comb for (int i = 0; i < DEPTH; i++) sel_src[i] = w[i];
`else
  always_comb for (int i = 0; i < DEPTH; i++) sel_src[i] = q[i];
`endif

  always_comb
    for (int i = 0; i < DEPTH; i++)
      elig[i] = sel_src[i].valid && sel_src[i].s1_rdy && sel_src[i].s2_rdy;

  alu_rs_select #(.N(DEPTH)) u_sel (
    .eligible (elig),
    .grant    (grant),
    .any      (any_elig)
  );

  always_comb begin
    pick = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) pick = sel_src[i];
  end

  // A dispatch operand can be woken by the broadcast happening in its own dispatch cycle.
  always_comb begin
    disp_raw         = '0;
    disp_raw.valid   = 1'b1;
    disp_raw.func    = disp_func;
    disp_raw.s1_rdy  = disp_src1_rdy;
    disp_raw.s1_val  = disp_src1_val;
    disp_raw.s1_tag  = TAG_MAX'(disp_src1_tag);
    disp_raw.s2_rdy  = disp_src2_rdy;
    disp_raw.s2_val  = disp_src2_val;
    disp_raw.s2_tag  = TAG_MAX'(disp_src2_tag);
    disp_raw.dst_tag = TAG_MAX'(disp_dst_tag);
    disp_e           = rs_wake(disp_raw, cdb_valid, cdb_tag_x, cdb_data);
  end

  // Slots at and above the granted one take their younger neighbour; the new entry lands at the tail.
  always_comb begin
    past = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      past  = past | (iss_fire & grant[i]);
      nq[i] = past ? w[i+1] : w[i];
      if (disp_fire && widx == CW'(i)) nq[i] = disp_e;
    end
  end

  assign unused_pick = ^{pick.valid, pick.s1_rdy, pick.s1_tag, pick.s2_rdy,
                         pick.s2_tag, pick.dst_tag};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count       <= '0;
      iss_valid   <= 1'b0;
      iss_in1     <= '0;
      iss_in2     <= '0;
      iss_func    <= '0;
      iss_dst_tag <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count     <= '0;
      iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
      count <= count + CW'(disp_fire) - CW'(iss_fire);
      if (load_iss) begin
        iss_valid <= any_elig;
        if (any_elig) begin
          iss_in1     <= pick.s1_val;
          iss_in2     <= pick.s2_val;
          iss_func    <= pick.func;
          iss_dst_tag <= pick.dst_tag[TAG_W-1:0];
        end
      end
    end
  end

endmodule
